// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
package disp_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned HEX_W     = 7;
  localparam int unsigned SEG_W     = 8;
  localparam int unsigned ANODE_W   = 4;
  localparam int unsigned VIEW_W    = 16;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned DSEL_W    = 7;
  localparam int unsigned PC_W      = 9;
  localparam int unsigned TEST_W    = 32;
  localparam int unsigned STEPCNT_W = 8;
  localparam int unsigned CLKCNT_W  = 16;

  // Active-low gfedcba patterns for each hex nibble
  localparam logic [HEX_W-1:0] HEX_0 = 7'h40;
  localparam logic [HEX_W-1:0] HEX_1 = 7'h79;
  localparam logic [HEX_W-1:0] HEX_2 = 7'h24;
  localparam logic [HEX_W-1:0] HEX_3 = 7'h30;
  localparam logic [HEX_W-1:0] HEX_4 = 7'h19;
  localparam logic [HEX_W-1:0] HEX_5 = 7'h12;
  localparam logic [HEX_W-1:0] HEX_6 = 7'h02;
  localparam logic [HEX_W-1:0] HEX_7 = 7'h78;
  localparam logic [HEX_W-1:0] HEX_8 = 7'h00;
  localparam logic [HEX_W-1:0] HEX_9 = 7'h10;
  localparam logic [HEX_W-1:0] HEX_A = 7'h08;
  localparam logic [HEX_W-1:0] HEX_B = 7'h03;
  localparam logic [HEX_W-1:0] HEX_C = 7'h46;
  localparam logic [HEX_W-1:0] HEX_D = 7'h21;
  localparam logic [HEX_W-1:0] HEX_E = 7'h06;
  localparam logic [HEX_W-1:0] HEX_F = 7'h0E;
  localparam logic [HEX_W-1:0] HEX_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0]   SEG_OFF   = 8'hFF;
  localparam logic [ANODE_W-1:0] ANODE_OFF = 4'hF;

  typedef enum logic [SEL_W-1:0] {
    VIEW_TEST_LO = 2'b00,
    VIEW_TEST_HI = 2'b01,
    VIEW_PC      = 2'b10,
    VIEW_CLK     = 2'b11
  } view_sel_e;

  typedef struct packed {
    logic [ANODE_W-1:0] anode;
    logic [SEG_W-1:0]   seg;
  } disp_out_t;

endpackage

// File: rtl/disp_scan_if.sv
// Debug-value inputs from the CPU top plus the display pins they drive.
interface disp_scan_if;
  import disp_pkg::*;

  logic [STEPCNT_W-1:0] disp_clock_count;
  logic [CLKCNT_W-1:0]  clock_count;
  logic [PC_W-1:0]      o_pc;
  logic [TEST_W-1:0]    test_out;
  logic [DSEL_W-1:0]    disp_sel;
  logic [ANODE_W-1:0]   disp_anode;
  logic [SEG_W-1:0]     disp_seg;

  modport master (
    output disp_clock_count, clock_count, o_pc, test_out, disp_sel,
    input  disp_anode, disp_seg
  );

  modport slave (
    input  disp_clock_count, clock_count, o_pc, test_out, disp_sel,
    output disp_anode, disp_seg
  );
endinterface

// File: rtl/disp_scan_hex_to_seg.sv
// Nibble to active-low gfedcba segment decoder.
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [HEX_W-1:0] seg_c
);

  always_comb begin
    seg_c = HEX_BLANK;
    case (nibble)
      4'h0: seg_c = HEX_0;
      4'h1: seg_c = HEX_1;
      4'h2: seg_c = HEX_2;
      4'h3: seg_c = HEX_3;
      4'h4: seg_c = HEX_4;
      4'h5: seg_c = HEX_5;
      4'h6: seg_c = HEX_6;
      4'h7: seg_c = HEX_7;
      4'h8: seg_c = HEX_8;
      4'h9: seg_c = HEX_9;
      4'hA: seg_c = HEX_A;
      4'hB: seg_c = HEX_B;
      4'hC: seg_c = HEX_C;
      4'hD: seg_c = HEX_D;
      4'hE: seg_c = HEX_E;
      4'hF: seg_c = HEX_F;
      default: seg_c = HEX_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// 4-digit multiplexed 7-segment scanner: per-frame snapshot of a selectable
// 16-bit debug view, blanking gap at each slot start, registered pins.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned BLANK_CYCLES = 4,   // 1 .. 2^DIV_WIDTH-1
  parameter bit          LZ_BLANK     = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  disp_scan_if.slave bus
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [1:0]           idx;
  logic [VIEW_W-1:0]    snap;
  logic [SEL_W-1:0]     snap_sel;
  disp_out_t            out_q;

  logic [VIEW_W-1:0] view_c;
  logic              frame_start_c;
  logic              slot_end_c;
  logic              show_c;
  logic [NIB_W-1:0]  nibble_c;
  logic [HEX_W-1:0]  hex_c;
  logic              lz_blank_c;
  disp_out_t         out_c;

  // Register index and PC MSB are not displayed by this block
  wire unused_bits_c = ^{bus.disp_sel[DSEL_W-1:SEL_W], bus.o_pc[PC_W-1]};

  always_comb begin
    view_c = bus.test_out[15:0];
    case (view_sel_e'(bus.disp_sel[SEL_W-1:0]))
      VIEW_TEST_LO: view_c = bus.test_out[15:0];
      VIEW_TEST_HI: view_c = bus.test_out[31:16];
      VIEW_PC:      view_c = {bus.disp_clock_count, bus.o_pc[7:0]};
      VIEW_CLK:     view_c = bus.clock_count;
      default:      view_c = bus.test_out[15:0];
    endcase
  end

  assign frame_start_c = (cnt == '0) && (idx == 2'd0);
  assign slot_end_c    = (cnt == '1);
  assign show_c        = (cnt >= DIV_WIDTH'(BLANK_CYCLES));
  assign nibble_c      = snap[{idx, 2'b00} +: NIB_W];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_c),
    .seg_c  (hex_c)
  );

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    lz_blank_c = 1'b0;
    case (idx)
      2'd1:    lz_blank_c = (snap[15:4]  == '0);
      2'd2:    lz_blank_c = (snap[15:8]  == '0);
      2'd3:    lz_blank_c = (snap[15:12] == '0);
      default: lz_blank_c = 1'b0;
    endcase
    if (!LZ_BLANK) lz_blank_c = 1'b0;
  end

  always_comb begin
    out_c.anode = ANODE_OFF;
    out_c.seg   = SEG_OFF;
    if (show_c) begin
      out_c.anode = ~(ANODE_W'(1) << idx);
      out_c.seg   = {(idx != snap_sel), (lz_blank_c ? HEX_BLANK : hex_c)};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= 2'd0;
      snap        <= '0;
      snap_sel    <= '0;
      out_q.anode <= ANODE_OFF;
      out_q.seg   <= SEG_OFF;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
      if (slot_end_c) idx <= idx + 2'd1;
      // Snapshot lands in the blank phase of slot 0, so a frame never tears
      if (frame_start_c) begin
        snap     <= view_c;
        snap_sel <= bus.disp_sel[SEL_W-1:0];
      end
      out_q <= out_c;
    end
  end

  assign bus.disp_anode = out_q.anode;
  assign bus.disp_seg   = out_q.seg;

endmodule
